uart_baud_gen: RTL

Parametrised baud-rate tick generator for the UART. It replaces the fixed-divider clock generator with a fractional phase accumulator (NCO), so all eight standard rates are accurate from any system clock. It produces single-cycle enable pulses for oversampling, TX bit timing and RX mid-bit sampling. Rate changes are deferred to a TX bit boundary. Sits between the clock domain root and the uart_tx / uart_rx engines, which consume the ticks as clock enables on clk_50M.

---
 rtl/uart_pkg.sv | 68 ++++++
 rtl/uart_baud_nco.sv | 54 +++++
 rtl/uart_baud_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Purpose  : Shared constants and elaboration-time helpers for the UART baud
//            generator: the standard baud table, the rate-select width, the
//            NCO increment calculation and the increment range check.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Width of the rate-select field (eight standard rates).
    localparam int BD_SEL_W    = 3;
    localparam int C_NUM_RATES = 1 << BD_SEL_W;

    // Baud rates indexed by bd_sel.
    localparam int C_BAUD_TABLE [C_NUM_RATES] = '{
        1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200
    };

    // Phase increment for one rate:
    //   round(baud * os * 2^acc_w / clk_hz)
    // Rounding is done as floor((2*num + den) / (2*den)) so it stays in
    // integer arithmetic.
    function automatic longint calc_inc(
        input longint baud,
        input longint clk_hz,
        input int     os,
        input int     acc_w
    );
        longint num;
        num = baud * longint'(os) * (longint'(1) << acc_w);
        return ((2 * num) + clk_hz) / (2 * clk_hz);
    endfunction

    // An increment is usable only if it is non-zero (otherwise no ticks)
    // and strictly below 2^acc_w (otherwise the tick rate would reach or
    // exceed the system clock).
    function automatic bit inc_in_range(
        input longint inc,
        input int     acc_w
    );
        return (inc != 0) && (inc < (longint'(1) << acc_w));
    endfunction

    // Checks every entry of the baud table against inc_in_range.
    function automatic bit rate_table_ok(
        input longint clk_hz,
        input int     os,
        input int     acc_w
    );
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < C_NUM_RATES; i++) begin
            if (!inc_in_range(calc_inc(longint'(C_BAUD_TABLE[i]), clk_hz, os, acc_w), acc_w)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Oversample factor must be even and at least 4 so that the mid-bit
    // sample point and the bit boundary are distinct ticks.
    function automatic bit oversample_ok(input int os);
        return (os >= 4) && ((os % 2) == 0);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_nco.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_nco
// Purpose  : Fractional phase accumulator. Each enabled cycle adds inc to
//            the accumulator modulo 2^ACC_W; the carry out of that addition
//            is registered as the oversample tick.
// Ports    : clk_50M    in   system clock
//            reset      in   synchronous active-high reset
//            en         in   accumulate enable; low holds the accumulator
//            clr        in   clears accumulator and carry (rate apply)
//            inc        in   phase increment for the current rate
//            carry_nxt  out  carry generated this cycle (feeds tick logic
//                            that must line up with the registered carry)
//            carry      out  registered carry, i.e. the os_tick pulse
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_nco #(
    parameter int ACC_W = 24
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [ACC_W-1:0] inc,
    output logic             carry_nxt,
    output logic             carry
);

    logic [ACC_W-1:0] r_acc;
    logic             r_carry;
    logic [ACC_W:0]   w_sum;

    // One extra bit so the wrap past 2^ACC_W shows up as the carry.
    assign w_sum = {1'b0, r_acc} + {1'b0, inc};

    // A clear discards this cycle's sum, so no carry may escape from it.
    assign carry_nxt = en & ~clr & w_sum[ACC_W];

    always_ff @(posedge clk_50M) begin
        if (reset || clr) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (en) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_carry <= w_sum[ACC_W];
        end else begin
            r_carry <= 1'b0;
        end
    end

    assign carry = r_carry;

endmodule : uart_baud_nco
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Baud-rate tick generator for the UART. A fractional NCO makes
//            the oversample tick; counters derive the TX bit tick and the RX
//            mid-bit sample strobe. Rate changes are held pending until a TX
//            bit boundary (or applied at once while disabled).
// Ports    : clk_50M       in   system clock, all logic on posedge
//            reset         in   synchronous active-high reset
//            en            in   generator enable; low freezes acc/counters
//            bd_sel[2:0]   in   requested rate (1200 .. 115200 baud)
//            rx_sync       in   RX start-bit pulse; realigns rx_sample
//            os_tick       out  oversample enable, one cycle wide
//            tx_tick       out  bit-period enable, every OVERSAMPLE os_ticks
//            rx_sample     out  mid-bit sample enable for RX
//            cur_sel[2:0]  out  rate currently in effect
//            rate_pending  out  a requested rate change awaits application
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int ACC_W      = 24
) (
    input  logic                clk_50M,
    input  logic                reset,
    input  logic                en,
    input  logic [BD_SEL_W-1:0] bd_sel,
    input  logic                rx_sync,
    output logic                os_tick,
    output logic                tx_tick,
    output logic                rx_sample,
    output logic [BD_SEL_W-1:0] cur_sel,
    output logic                rate_pending
);

    localparam int               C_CNT_W   = $clog2(OVERSAMPLE);
    localparam logic [C_CNT_W-1:0] C_OS_LAST = C_CNT_W'(OVERSAMPLE - 1);
    localparam logic [C_CNT_W-1:0] C_RX_MID  = C_CNT_W'(OVERSAMPLE / 2 - 1);

    // ------------------------------------------------------------------
    // Configuration checks
    // ------------------------------------------------------------------
    generate
        if (!rate_table_ok(longint'(CLK_HZ), OVERSAMPLE, ACC_W)) begin : g_bad_inc
            $error("uart_baud_gen: a phase increment is 0 or >= 2^ACC_W for this CLK_HZ/OVERSAMPLE/ACC_W");
        end
        if (!oversample_ok(OVERSAMPLE)) begin : g_bad_os
            $error("uart_baud_gen: OVERSAMPLE must be even and >= 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Increment table, fixed at elaboration
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] w_inc_table [C_NUM_RATES];

    generate
        for (genvar gi = 0; gi < C_NUM_RATES; gi++) begin : g_inc
            localparam longint C_INC =
                calc_inc(longint'(C_BAUD_TABLE[gi]), longint'(CLK_HZ), OVERSAMPLE, ACC_W);
            assign w_inc_table[gi] = ACC_W'(C_INC);
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BD_SEL_W-1:0] r_cur_sel;
    logic [BD_SEL_W-1:0] r_pending_sel;
    logic                r_rate_pending;
    logic [C_CNT_W-1:0]  r_tx_cnt;
    logic [C_CNT_W-1:0]  r_rx_cnt;
    logic                r_tx_tick;
    logic                r_rx_sample;

    logic [ACC_W-1:0]    w_inc;
    logic                w_tick;
    logic                w_os_tick;
    logic                w_apply;

    assign w_inc = w_inc_table[r_cur_sel];

    // A pending rate takes effect at the end of the cycle that shows
    // tx_tick (bit boundary), or straight away while the generator is off.
    assign w_apply = r_rate_pending & (~en | r_tx_tick);

    uart_baud_nco #(
        .ACC_W     (ACC_W)
    ) u_nco (
        .clk_50M   (clk_50M),
        .reset     (reset),
        .en        (en),
        .clr       (w_apply),
        .inc       (w_inc),
        .carry_nxt (w_tick),
        .carry     (w_os_tick)
    );

    // ------------------------------------------------------------------
    // Rate-change control
    // ------------------------------------------------------------------
    // r_pending_sel tracks bd_sel every cycle, so a later request simply
    // overwrites an earlier one. The pending flag is recomputed each cycle
    // against the rate in effect (or the one being applied), which makes a
    // request that returns to cur_sel cancel itself.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_cur_sel      <= bd_sel;
            r_pending_sel  <= bd_sel;
            r_rate_pending <= 1'b0;
        end else begin
            r_pending_sel <= bd_sel;
            if (w_apply) begin
                r_cur_sel      <= r_pending_sel;
                r_rate_pending <= (bd_sel != r_pending_sel);
            end else begin
                r_rate_pending <= (bd_sel != r_cur_sel);
            end
        end
    end

    // ------------------------------------------------------------------
    // Tick counters
    // ------------------------------------------------------------------
    // The counters advance on the same edge that registers os_tick, so the
    // tx/rx strobes are decided from the count value before this tick and
    // are registered alongside it.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_tx_tick   <= 1'b0;
            r_rx_sample <= 1'b0;
        end else begin
            r_tx_tick   <= w_tick & (r_tx_cnt == C_OS_LAST);
            // A coincident rx_sync realigns instead of sampling.
            r_rx_sample <= w_tick & ~rx_sync & (r_rx_cnt == C_RX_MID);

            if (w_apply) begin
                r_tx_cnt <= '0;
                r_rx_cnt <= '0;
            end else begin
                if (w_tick) begin
                    r_tx_cnt <= (r_tx_cnt == C_OS_LAST) ? '0 : r_tx_cnt + C_CNT_W'(1);
                end
                if (rx_sync) begin
                    r_rx_cnt <= '0;
                end else if (w_tick) begin
                    r_rx_cnt <= (r_rx_cnt == C_OS_LAST) ? '0 : r_rx_cnt + C_CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign os_tick      = w_os_tick;
    assign tx_tick      = r_tx_tick;
    assign rx_sample    = r_rx_sample;
    assign cur_sel      = r_cur_sel;
    assign rate_pending = r_rate_pending;

endmodule : uart_baud_gen
`default_nettype wire
